// File: rtl/excep_commit_ctrl_pkg.sv
// Shared constants and types for the writeback trap sequencer.
package excep_commit_ctrl_pkg;

   // Default widths reused across the pipeline.
   localparam int unsigned PC_W_DEFAULT = 32;
   localparam int unsigned FLUSH_CNT_W  = 4;

   // State encodings.
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_FLUSH    = 2'd1;
   localparam logic [1:0] ST_REDIRECT = 2'd2;

   // Interrupts are recorded with ecode 0 and esubcode 0.
   localparam logic [5:0] ECODE_INT    = 6'h00;
   localparam logic [8:0] ESUBCODE_INT = 9'h000;

   typedef enum logic [1:0] {
      StIdle     = ST_IDLE,
      StFlush    = ST_FLUSH,
      StRedirect = ST_REDIRECT
   } state_e;

endpackage

// File: rtl/excep_commit_ctrl.sv
// Trap sequencer at the WB boundary: commits, exceptions, interrupts and ertn.
// A trap flushes every stage register for FLUSH_CYCLES cycles, pulses the CSR
// update strobes once, and then holds a redirect to fetch until it is accepted.
module excep_commit_ctrl
   import excep_commit_ctrl_pkg::*;
#(
   parameter int unsigned PC_W         = PC_W_DEFAULT,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wb_valid_i,
   input  logic [PC_W-1:0] wb_pc_i,
   input  logic            wb_excep_i,
   input  logic [5:0]      wb_ecode_i,
   input  logic [8:0]      wb_esubcode_i,
   input  logic [PC_W-1:0] wb_badv_i,
   input  logic            wb_ertn_i,
   input  logic            int_pending_i,
   input  logic [PC_W-1:0] eentry_i,
   input  logic [PC_W-1:0] era_i,
   output logic            wb_allowin_o,
   output logic            wb_we_kill_o,
   output logic            excep_flush_o,
   output logic            csr_excep_we_o,
   output logic            csr_ertn_we_o,
   output logic [PC_W-1:0] csr_era_o,
   output logic [5:0]      csr_ecode_o,
   output logic [8:0]      csr_esubcode_o,
   output logic [PC_W-1:0] csr_badv_o,
   output logic            redirect_valid_o,
   output logic [PC_W-1:0] redirect_pc_o,
   input  logic            redirect_ready_i
);

   // Counter preload: the trap-commit cycle already counts as one flush cycle.
   localparam logic [FLUSH_CNT_W-1:0] FlushInit =
      (FLUSH_CYCLES > 1) ? FLUSH_CNT_W'(FLUSH_CYCLES - 2) : '0;

   state_e                 state_q, state_d;
   logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [PC_W-1:0]        redirect_pc_q, redirect_pc_d;

   logic take_exc, take_int, take_ertn, trap;

   // Priority decode: exception > interrupt > ertn.
   always_comb begin
      take_exc  = wb_valid_i & wb_excep_i;
      take_int  = wb_valid_i & ~wb_excep_i & int_pending_i;
      take_ertn = wb_valid_i & ~wb_excep_i & ~int_pending_i & wb_ertn_i;
      trap      = take_exc | take_int | take_ertn;
   end

   // Next-state, counter, redirect target and all outputs.
   always_comb begin
      state_d          = state_q;
      flush_cnt_d      = flush_cnt_q;
      redirect_pc_d    = redirect_pc_q;
      wb_allowin_o     = 1'b0;
      wb_we_kill_o     = 1'b0;
      excep_flush_o    = 1'b0;
      csr_excep_we_o   = 1'b0;
      csr_ertn_we_o    = 1'b0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = redirect_pc_q;
      // Data outputs only matter while their strobe is high.
      csr_era_o        = wb_pc_i;
      csr_badv_o       = wb_badv_i;
      csr_ecode_o      = wb_excep_i ? wb_ecode_i : ECODE_INT;
      csr_esubcode_o   = wb_excep_i ? wb_esubcode_i : ESUBCODE_INT;

      case (state_q)
         StIdle: begin
            if (trap) begin
               excep_flush_o  = 1'b1;
               wb_we_kill_o   = take_exc | take_int;
               csr_excep_we_o = take_exc | take_int;
               csr_ertn_we_o  = take_ertn;
               redirect_pc_d  = take_ertn ? era_i : eentry_i;
               if (FLUSH_CYCLES == 1) begin
                  state_d = StRedirect;
               end else begin
                  state_d     = StFlush;
                  flush_cnt_d = FlushInit;
               end
            end else begin
               wb_allowin_o = 1'b1;
            end
         end
         StFlush: begin
            excep_flush_o = 1'b1;
            if (flush_cnt_q == '0) begin
               state_d = StRedirect;
            end else begin
               flush_cnt_d = flush_cnt_q - 1'b1;
            end
         end
         StRedirect: begin
            redirect_valid_o = 1'b1;
            wb_allowin_o     = 1'b1;
            if (redirect_ready_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         flush_cnt_q   <= '0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         flush_cnt_q   <= flush_cnt_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

endmodule
